krv_uart_rx: RTL and testbench

- UART receive engine for the krv_e peripheral subsystem.
- Counterpart of the SoC's UART transmitter. It deserialises the UART_RX pin (8N1, LSB first) into bytes.
- Presents each byte through a valid/ack register-style interface to the APB UART register block.
- Flags framing errors and overruns as sticky status bits.

---
 rtl/krv_uart_rx.sv | 150 +++++++++++++++
 tb/tb_krv_uart_rx.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/krv_uart_rx.sv
// UART 8N1 receive engine: synchronises the RX pin, deserialises LSB-first
// bytes and presents them through a valid/ack interface with sticky errors.
//
// state     | meaning
// IDLE      | line idle, waiting for rxs==0 (start edge)
// START     | half-bit wait, confirm start bit or reject glitch
// DATA      | sample 8 data bits, one per baud_div cycles
// STOP      | sample stop bit, deliver byte or flag framing error
// WAIT_IDLE | after a framing error, wait for the line to return high
module krv_uart_rx #(
  parameter int DIV_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 cpu_clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  input  logic [DIV_WIDTH-1:0] baud_div,
  output logic [7:0]           rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 err_clr
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   fe_q, fe_d;
  logic                   ovr_q, ovr_d;
  logic                   rxs;
  logic                   tick;
  logic [DIV_WIDTH-1:0]   tgt;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], uart_rx};
  assign rxs    = sync_q[SYNC_STAGES-1];

  // START waits half a bit (sample at T0+H); other states wait a full bit.
  assign tgt  = (state_q == START) ? ((div_q >> 1) - DIV_ONE) : (div_q - DIV_ONE);
  assign tick = (cnt_q == tgt);

  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '1;
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!rxs) state_d = START;
      START:     if (tick) state_d = rxs ? IDLE : DATA;
      DATA:      if (tick && (bit_q == 3'd7)) state_d = STOP;
      STOP:      if (tick) state_d = rxs ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rxs) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q + DIV_ONE;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = fe_q;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rxs) div_d = baud_div;
      end
      START: if (tick) cnt_d = '0;
      DATA: begin
        if (tick) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
        end
      end
      STOP: if (tick) cnt_d = '0;
      default: cnt_d = '0;
    endcase

    if (err_clr) begin
      fe_d  = 1'b0;
      ovr_d = 1'b0;
    end
    if (rx_ack) valid_d = 1'b0;
    // A load in the same cycle as rx_ack or err_clr takes priority.
    if ((state_q == STOP) && tick) begin
      if (rxs) begin
        data_d  = shift_q;
        valid_d = 1'b1;
        if (valid_q && !rx_ack) ovr_d = 1'b1;
      end else begin
        fe_d = 1'b1;
      end
    end
    busy_d = (state_d != IDLE);
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign rx_busy   = busy_q;
  assign frame_err = fe_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_krv_uart_rx.sv
// Self-checking bench for krv_uart_rx: directed scenarios plus randomized
// frames, compared against a byte-level model of the receive register.
module tb_krv_uart_rx;

  localparam int SYNC = 2;

  logic        cpu_clk = 1'b0;
  logic        rst;
  logic        uart_rx;
  logic [15:0] baud_div;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ack;
  logic        rx_busy;
  logic        frame_err;
  logic        overrun;
  logic        err_clr;

  krv_uart_rx #(.DIV_WIDTH(16), .SYNC_STAGES(SYNC)) dut (
    .cpu_clk  (cpu_clk),
    .rst      (rst),
    .uart_rx  (uart_rx),
    .baud_div (baud_div),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ack   (rx_ack),
    .rx_busy  (rx_busy),
    .frame_err(frame_err),
    .overrun  (overrun),
    .err_clr  (err_clr)
  );

  always #5 cpu_clk = ~cpu_clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rise_cyc = -1;
  int rise_cnt = 0;
  int t_start = 0;
  logic prev_valid = 1'b0;

  // Reference model of the byte register and sticky flags
  logic [7:0] m_data;
  logic       m_valid, m_ovr, m_fe;

  always @(posedge cpu_clk) cyc <= cyc + 1;

  always @(negedge cpu_clk) begin
    if (rx_valid && !prev_valid) begin
      rise_cyc = cyc;
      rise_cnt = rise_cnt + 1;
    end
    prev_valid = rx_valid;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic exp_busy);
    chk({tag, ".data"},  rx_data,   m_data);
    chk({tag, ".valid"}, rx_valid,  m_valid);
    chk({tag, ".ovr"},   overrun,   m_ovr);
    chk({tag, ".fe"},    frame_err, m_fe);
    chk({tag, ".busy"},  rx_busy,   exp_busy);
  endtask

  task automatic m_reset();
    m_data = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
  endtask

  task automatic m_byte(input logic [7:0] b, input logic ack_same_cycle);
    if (m_valid && !ack_same_cycle) m_ovr = 1'b1;
    m_data  = b;
    m_valid = 1'b1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge cpu_clk);
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1; @(negedge cpu_clk); rx_ack = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1; @(negedge cpu_clk); err_clr = 1'b0;
    m_ovr = 1'b0; m_fe = 1'b0;
  endtask

  // Start bit, nbits data bits LSB first, then the stop bit when nbits==8.
  task automatic drive_frame(input logic [7:0] b, input logic stopv, input int nbits, input int div);
    t_start = cyc;
    uart_rx = 1'b0;
    repeat (div) @(negedge cpu_clk);
    for (int i = 0; i < nbits; i++) begin
      uart_rx = b[i];
      repeat (div) @(negedge cpu_clk);
    end
    if (nbits == 8) begin
      uart_rx = stopv;
      repeat (div) @(negedge cpu_clk);
    end
  endtask

  initial begin
    int div, rc, t, pred;
    logic [7:0] b;
    logic good;

    rst = 1'b1; uart_rx = 1'b1; rx_ack = 1'b0; err_clr = 1'b0; baud_div = 16'd16;
    m_reset();
    repeat (3) @(negedge cpu_clk);
    check_all("reset", 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge cpu_clk);

    // Basic receive with exact latency
    div = 16;
    drive_frame(8'h55, 1'b1, 8, div);
    @(negedge cpu_clk);
    chk("basic.rise_cycle", rise_cyc, t_start + SYNC + (div >> 1) + 9 * div + 1);
    m_byte(8'h55, 1'b0);
    check_all("basic", 1'b0);

    // Read, then back-to-back frames
    pulse_ack();
    drive_frame(8'hA5, 1'b1, 8, div);
    @(negedge cpu_clk);
    m_byte(8'hA5, 1'b0);
    check_all("a5", 1'b0);
    wait_until(rise_cyc + 20);
    pulse_ack();
    chk("ack.valid_drop", rx_valid, m_valid);
    drive_frame(8'h3C, 1'b1, 8, div);
    @(negedge cpu_clk);
    m_byte(8'h3C, 1'b0);
    check_all("b2b", 1'b0);

    // Overrun, then err_clr
    pulse_ack();
    drive_frame(8'h01, 1'b1, 8, div);
    drive_frame(8'h02, 1'b1, 8, div);
    @(negedge cpu_clk);
    m_byte(8'h01, 1'b0);
    m_byte(8'h02, 1'b0);
    check_all("overrun", 1'b0);
    pulse_clr();
    check_all("overrun.clr", 1'b0);

    // rx_ack in the load cycle: load wins, no overrun
    fork
      drive_frame(8'h77, 1'b1, 8, div);
      begin
        pred = cyc + SYNC + (div >> 1) + 9 * div;
        wait_until(pred);
        rx_ack = 1'b1; @(negedge cpu_clk); rx_ack = 1'b0;
      end
    join
    @(negedge cpu_clk);
    m_byte(8'h77, 1'b1);
    check_all("ack_vs_load", 1'b0);

    // Framing error with err_clr in the same cycle, then a long break
    fork
      drive_frame(8'hFF, 1'b0, 8, div);
      begin
        pred = cyc + SYNC + (div >> 1) + 9 * div;
        wait_until(pred);
        err_clr = 1'b1; @(negedge cpu_clk); err_clr = 1'b0;
      end
    join
    m_ovr = 1'b0;
    m_fe  = 1'b1;
    rc = rise_cnt;
    repeat (40 * div) @(negedge cpu_clk);
    chk("break.no_spurious", rise_cnt, rc);
    check_all("frame_err", 1'b1);
    uart_rx = 1'b1;
    repeat (2 * div) @(negedge cpu_clk);
    pulse_ack();
    drive_frame(8'h81, 1'b1, 8, div);
    @(negedge cpu_clk);
    m_byte(8'h81, 1'b0);
    check_all("after_break", 1'b0);
    chk("after_break.count", rise_cnt, rc + 1);

    // Randomized frames, divisors and host actions
    for (int n = 0; n < 10; n++) begin
      div = $urandom_range(8, 24);
      baud_div = 16'(div);
      b = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      fork
        drive_frame(b, good, 8, div);
        begin
          repeat (div * 3) @(negedge cpu_clk);
          baud_div = 16'($urandom_range(4, 30));
        end
      join
      if (good) m_byte(b, 1'b0);
      else m_fe = 1'b1;
      uart_rx = 1'b1;
      repeat (4) @(negedge cpu_clk);
      check_all($sformatf("rand%0d", n), 1'b0);
      case ($urandom_range(0, 2))
        0: pulse_ack();
        1: pulse_clr();
        default: ;
      endcase
      repeat (2) @(negedge cpu_clk);
    end

    // Glitch rejection
    pulse_ack();
    pulse_clr();
    baud_div = 16'd16;
    repeat (4) @(negedge cpu_clk);
    rc = rise_cnt;
    t = cyc;
    uart_rx = 1'b0;
    repeat (3) @(negedge cpu_clk);
    uart_rx = 1'b1;
    wait_until(t + SYNC + 8);
    chk("glitch.busy_at_sample", rx_busy, 1'b1);
    wait_until(t + SYNC + 9);
    chk("glitch.idle_by_t0p9", rx_busy, 1'b0);
    repeat (20) @(negedge cpu_clk);
    chk("glitch.no_byte", rise_cnt, rc);
    check_all("glitch", 1'b0);

    // Reset during data bit 4 of 0x5A, then 0x96
    div = 16;
    fork
      drive_frame(8'h5A, 1'b1, 5, div);
      begin
        t = cyc;
        wait_until(t + 5 * div + div / 2);
        rst = 1'b1;
      end
    join
    uart_rx = 1'b1;
    m_reset();
    check_all("rst_mid", 1'b0);
    repeat (5) @(negedge cpu_clk);
    rst = 1'b0;
    repeat (5) @(negedge cpu_clk);
    rc = rise_cnt;
    drive_frame(8'h96, 1'b1, 8, div);
    @(negedge cpu_clk);
    m_byte(8'h96, 1'b0);
    check_all("post_rst", 1'b0);
    chk("post_rst.count", rise_cnt, rc + 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
